acc_cpu_mc: RTL and testbench

ACC_CPU_MC -- requirements
Module: acc_cpu_mc

---
 rtl/acc_cpu_mc.sv | 140 ++++++++++++++
 tb/tb_acc_cpu_mc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_mc.sv
// rtl/acc_cpu_mc.sv - multi-cycle accumulator CPU with direct/indirect addressing
// One memory port shared by fetch, pointer read and operand access; stalls on mem_ready.
module acc_cpu_mc #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_indirect,
  output logic [DW-1:0] acc,
  output logic [AW-1:0] pc,
  output logic          halted
);

  localparam logic [4:0] OP_LDA = 5'h01, OP_STA = 5'h02, OP_ADD = 5'h03, OP_SUB = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05, OP_OR  = 5'h06, OP_XOR = 5'h07, OP_NOT = 5'h08;
  localparam logic [4:0] OP_JMP = 5'h09, OP_JZ  = 5'h0A, OP_JN  = 5'h0B, OP_LDI = 5'h0C;
  localparam logic [4:0] OP_HLT = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_INDIR, S_EXEC, S_HALT
  } state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_pc, r_ea;
  logic [DW-1:0] r_acc, r_ir;

  logic          w_mode, w_is_mem, w_is_jmp, w_take;
  logic [4:0]    w_op;
  logic [AW-1:0] w_field;
  logic          w_unused_ir;

  assign w_mode      = r_ir[DW-1];
  assign w_op        = r_ir[DW-2:DW-6];
  assign w_field     = r_ir[AW-1:0];
  assign w_unused_ir = ^r_ir;
  assign w_is_mem    = (w_op >= OP_LDA) && (w_op <= OP_XOR);
  assign w_is_jmp    = (w_op >= OP_JMP) && (w_op <= OP_JN);

  // Jump condition is evaluated on the accumulator at the edge that resolves the jump.
  always_comb begin
    w_take = 1'b0;
    case (w_op)
      OP_JMP:  w_take = 1'b1;
      OP_JZ:   w_take = (r_acc == '0);
      OP_JN:   w_take = r_acc[DW-1];
      default: w_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_indirect = 1'b0;
    mem_addr     = r_pc;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_op == OP_HLT)                       w_next = S_HALT;
        else if ((w_is_mem || w_is_jmp) && w_mode) w_next = S_INDIR;
        else if (w_is_mem)                        w_next = S_EXEC;
        else                                      w_next = S_FETCH;
      end
      S_INDIR: begin
        mem_req      = 1'b1;
        mem_indirect = 1'b1;
        mem_addr     = w_field;
        if (mem_ready) w_next = w_is_jmp ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        mem_req  = 1'b1;
        mem_we   = (w_op == OP_STA);
        mem_addr = r_ea;
        if (mem_ready) w_next = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= '0;
      r_acc <= '0;
      r_ir  <= '0;
      r_ea  <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + AW'(1);
        end
        S_DECODE: begin
          if (w_op == OP_NOT) r_acc <= ~r_acc;
          if (w_op == OP_LDI) r_acc <= DW'(w_field);
          if (w_is_jmp && !w_mode && w_take) r_pc <= w_field;
          if (w_is_mem && !w_mode) r_ea <= w_field;
        end
        S_INDIR: if (mem_ready) begin
          r_ea <= mem_rdata[AW-1:0];
          if (w_is_jmp && w_take) r_pc <= mem_rdata[AW-1:0];
        end
        S_EXEC: if (mem_ready) begin
          case (w_op)
            OP_LDA:  r_acc <= mem_rdata;
            OP_ADD:  r_acc <= r_acc + mem_rdata;
            OP_SUB:  r_acc <= r_acc - mem_rdata;
            OP_AND:  r_acc <= r_acc & mem_rdata;
            OP_OR:   r_acc <= r_acc | mem_rdata;
            OP_XOR:  r_acc <= r_acc ^ mem_rdata;
            default: r_acc <= r_acc;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mem_wdata = r_acc;
  assign acc       = r_acc;
  assign pc        = r_pc;
  assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_acc_cpu_mc.sv
// tb/tb_acc_cpu_mc.sv - directed vector bench for acc_cpu_mc
// Table of single-instruction programs plus hand sequences for stalls, reset and pc wrap.
module tb_acc_cpu_mc;

  logic        clk;
  logic        rst;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_indirect, halted;
  logic [9:0]  mem_addr, pc;
  logic [15:0] mem_wdata, acc;

  logic        rst2;
  logic [11:0] mem_rdata2;
  logic        mem_ready2;
  logic        mem_req2, mem_we2, mem_indirect2, halted2;
  logic [3:0]  mem_addr2, pc2;
  logic [11:0] mem_wdata2, acc2;

  logic [15:0] mem [0:1023];

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;

  acc_cpu_mc #(.DW(16), .AW(10)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_indirect(mem_indirect), .acc(acc), .pc(pc), .halted(halted)
  );

  acc_cpu_mc #(.DW(12), .AW(4)) dut_small (
    .clk(clk), .rst(rst2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_indirect(mem_indirect2), .acc(acc2), .pc(pc2), .halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata  = mem[mem_addr];
  assign mem_rdata2 = 12'h000;
  assign mem_ready2 = 1'b1;

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
  end

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [9:0]  ldi;
    logic [15:0] opnd;
    logic [15:0] exp_acc;
    int          exp_edges;
    int          exp_wr;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] ins(input logic m, input logic [4:0] op, input logic [9:0] a);
    return {m, op, a};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int edges;
    int wc0;
    logic ok;

    rst = 1'b1; rst2 = 1'b1; mem_ready = 1'b1;
    clear_mem();
    #12;
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_mem_we", mem_we, 1'b0);
    check("reset_indirect", mem_indirect, 1'b0);
    check("reset_halted", halted, 1'b0);
    check("reset_pc", pc, 10'd0);
    check("reset_acc", acc, 16'd0);

    vt[0]  = '{"lda",     5'h01, 10'h005, 16'h1234, 16'h1234, 8, 0};
    vt[1]  = '{"add",     5'h03, 10'h005, 16'h0003, 16'h0008, 8, 0};
    vt[2]  = '{"add_wrap",5'h03, 10'h3FF, 16'hFC01, 16'h0000, 8, 0};
    vt[3]  = '{"sub",     5'h04, 10'h003, 16'h0005, 16'hFFFE, 8, 0};
    vt[4]  = '{"and",     5'h05, 10'h2AA, 16'h0F0F, 16'h020A, 8, 0};
    vt[5]  = '{"or",      5'h06, 10'h2AA, 16'h0F0F, 16'h0FAF, 8, 0};
    vt[6]  = '{"xor",     5'h07, 10'h2AA, 16'h0F0F, 16'h0DA5, 8, 0};
    vt[7]  = '{"sta",     5'h02, 10'h155, 16'h0000, 16'h0155, 8, 1};
    vt[8]  = '{"not",     5'h08, 10'h00F, 16'h0000, 16'hFFF0, 7, 0};
    vt[9]  = '{"nop",     5'h00, 10'h123, 16'h0000, 16'h0123, 7, 0};
    vt[10] = '{"unknown", 5'h0D, 10'h123, 16'h0000, 16'h0123, 7, 0};
    vt[11] = '{"ldi",     5'h0C, 10'h007, 16'h0000, 16'h0064, 7, 0};

    // Program: LDI ldi; <op> 100; HLT with operand at M[100]
    for (int i = 0; i < 12; i++) begin
      rst = 1'b1; mem_ready = 1'b1;
      clear_mem();
      mem[0]   = ins(1'b0, 5'h0C, vt[i].ldi);
      mem[1]   = ins(1'b0, vt[i].op, 10'd100);
      mem[2]   = 16'h7C00;
      mem[100] = vt[i].opnd;
      wc0 = wr_cnt;
      release_rst();
      edges = 0;
      for (int k = 0; k < 100 && !halted; k++) begin
        step();
        edges++;
      end
      check({vt[i].name, "_halted"}, halted, 1'b1);
      check({vt[i].name, "_edges"}, edges, vt[i].exp_edges);
      check({vt[i].name, "_acc"}, acc, vt[i].exp_acc);
      check({vt[i].name, "_pc"}, pc, 10'd3);
      check({vt[i].name, "_writes"}, wr_cnt - wc0, vt[i].exp_wr);
      if (vt[i].exp_wr == 1) begin
        check({vt[i].name, "_wr_addr"}, wr_addr, 10'd100);
        check({vt[i].name, "_wr_data"}, wr_data, {6'd0, vt[i].ldi});
      end
      step(); step(); step();
      check({vt[i].name, "_halt_pc_frozen"}, pc, 10'd3);
      check({vt[i].name, "_halt_no_req"}, mem_req, 1'b0);
    end

    // Indirect LDA: fetch 0, pointer read 30, operand read 40
    rst = 1'b1; clear_mem();
    mem[0] = 16'h841E; mem[1] = 16'h7C00; mem[30] = 16'd40; mem[40] = 16'h1234;
    release_rst();
    step();
    check("ind_fetch_addr", {mem_req, mem_indirect, mem_addr}, {1'b1, 1'b0, 10'd0});
    step();
    check("ind_decode_noreq", {mem_req, mem_indirect}, 2'b00);
    step();
    check("ind_ptr_read", {mem_req, mem_we, mem_indirect, mem_addr}, {1'b1, 1'b0, 1'b1, 10'd30});
    step();
    check("ind_operand_read", {mem_req, mem_we, mem_indirect, mem_addr}, {1'b1, 1'b0, 1'b0, 10'd40});
    step();
    check("ind_acc", acc, 16'h1234);
    check("ind_next_fetch", {mem_req, mem_addr}, {1'b1, 10'd1});

    // JZ 9 taken with acc=0, then JN 2 not taken
    rst = 1'b1; clear_mem();
    mem[0] = 16'h2809; mem[9] = 16'h2C02; mem[10] = 16'h7C00;
    release_rst();
    step(); step(); step();
    check("jz_taken_pc", pc, 10'd9);
    check("jz_fetch_addr", mem_addr, 10'd9);
    step(); step();
    check("jn_not_taken_pc", pc, 10'd10);
    check("jn_fetch_addr", {mem_req, mem_addr}, {1'b1, 10'd10});

    // Indirect JMP through M[50] resolves in 3 cycles
    rst = 1'b1; clear_mem();
    mem[0] = 16'hA432; mem[50] = 16'd7; mem[7] = 16'h7C00;
    release_rst();
    step(); step(); step(); step();
    check("ijmp_pc", pc, 10'd7);
    check("ijmp_fetch", {mem_req, mem_indirect, mem_addr}, {1'b1, 1'b0, 10'd7});

    // STA 50 stalled 5 cycles with acc=0xBEEF
    rst = 1'b1; clear_mem();
    mem[0] = 16'h043C; mem[60] = 16'hBEEF; mem[1] = 16'h0832; mem[2] = 16'h7C00;
    release_rst();
    for (int k = 0; k < 5; k++) step();
    mem_ready = 1'b0;
    wc0 = wr_cnt;
    step();
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (!(mem_req && mem_we && !mem_indirect && mem_addr == 10'd50 && mem_wdata == 16'hBEEF))
        ok = 1'b0;
      if (c == 5) mem_ready = 1'b1;
      step();
    end
    check("sta_stall_stable", ok, 1'b1);
    check("sta_one_write", wr_cnt - wc0, 1);
    check("sta_wr_addr", wr_addr, 10'd50);
    check("sta_wr_data", wr_data, 16'hBEEF);
    check("sta_after_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 10'd2});

    // Reset while STA waits in EXEC
    rst = 1'b1; mem_ready = 1'b1;
    release_rst();
    for (int k = 0; k < 5; k++) step();
    mem_ready = 1'b0;
    wc0 = wr_cnt;
    step(); step(); step();
    check("rstmid_waiting", {mem_req, mem_we}, 2'b11);
    rst = 1'b1;
    #1;
    check("rstmid_req_drop", {mem_req, mem_we, mem_indirect}, 3'b000);
    check("rstmid_acc", acc, 16'd0);
    check("rstmid_pc", pc, 10'd0);
    mem_ready = 1'b1;
    release_rst();
    check("rstmid_no_req_idle", mem_req, 1'b0);
    step();
    check("rstmid_refetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 10'd0});
    check("rstmid_acc_after", acc, 16'd0);
    check("rstmid_no_write", wr_cnt - wc0, 0);

    // Small instance: NOP stream wraps pc 15 -> 0
    @(negedge clk);
    rst2 = 1'b0;
    edges = 0;
    for (int k = 0; k < 100 && !(mem_req2 && mem_addr2 == 4'hF); k++) begin
      step();
      edges++;
    end
    check("wrap_fetch15_edges", edges, 31);
    step();
    check("wrap_pc_zero", pc2, 4'h0);
    step();
    check("wrap_fetch_addr0", {mem_req2, mem_addr2}, {1'b1, 4'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
